// File: rtl/logic_gate_pkg.sv
// Shared definitions for the registered logic gate unit.
//   OP_W    : opcode width
//   op_t    : the eight bitwise gate operations, applied as f(x, y)
//   state_t : fold state machine (IDLE, ACCUM)
package logic_gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/logic_gate_unit_gate_alu.sv
// gate_alu: combinational bitwise gate, result = f(x, y) selected by op.
// Ports:
//   x   [WIDTH-1:0] first operand (always operand A)
//   y   [WIDTH-1:0] second operand (B or the running fold)
//   op  [OP_W-1:0]  opcode, see op_t
//   f   [WIDTH-1:0] result
module gate_alu
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] f
);

  always_comb begin
    case (op_t'(op))
      OP_AND:    f = x & y;
      OP_OR:     f = x | y;
      OP_XOR:    f = x ^ y;
      OP_NAND:   f = ~(x & y);
      OP_NOR:    f = ~(x | y);
      OP_XNOR:   f = ~(x ^ y);
      OP_NOT_A:  f = ~x;
      default:   f = x;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered bitwise gate unit with valid/ready handshake
// and an accumulate mode that folds a stream of operands into one result.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  input beat handshake (in_ready = !out_valid || out_ready)
//   a, b, op             operands and opcode (b only on the first/only beat)
//   acc_en, acc_last     start a fold (sampled in IDLE) / final beat of a fold
//   out_valid/out_ready  result handshake
//   out, out_zero        registered result and its zero flag
//   acc_beats            number of beats folded into out (saturating)
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             acc_en,
  input  logic             acc_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic [CNT_W-1:0] acc_beats
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0] count, count_n, count_inc;
  logic [WIDTH-1:0] alu_y, alu_f;
  logic             accept;
  logic             load;
  logic [CNT_W-1:0] load_beats;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The first beat of any transaction pairs a with b; later fold beats pair a with acc.
  assign alu_y     = (state == ACCUM) ? acc : b;
  assign count_inc = (count == CNT_MAX) ? count : count + CNT_ONE;

  gate_alu #(.WIDTH(WIDTH)) u_gate_alu (
    .x  (a),
    .y  (alu_y),
    .op (op),
    .f  (alu_f)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    state_n    = state;
    acc_n      = acc;
    count_n    = count;
    load       = 1'b0;
    load_beats = CNT_ONE;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!acc_en) begin
            load = 1'b1;
          end else begin
            acc_n   = alu_f;
            count_n = CNT_ONE;
            if (acc_last) load = 1'b1;
            else          state_n = ACCUM;
          end
        end
        default: begin
          acc_n   = alu_f;
          count_n = count_inc;
          if (acc_last) begin
            load       = 1'b1;
            load_beats = count_inc;
            state_n    = IDLE;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      count <= count_n;
    end
  end

  // A load and a drain in the same cycle keep out_valid high: the new result simply replaces the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_zero  <= 1'b1;
      acc_beats <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= alu_f;
      out_zero  <= (alu_f == '0);
      acc_beats <= load_beats;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit. Two instances share all stimulus:
// dut (CNT_W=8) and dut_sat (CNT_W=2) for the beat counter saturation case.
module tb_logic_gate_unit;
  import logic_gate_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       acc_en, acc_last, out_ready;

  logic       in_ready, out_valid, out_zero;
  logic [7:0] out, acc_beats;
  logic       s_in_ready, s_out_valid, s_out_zero;
  logic [7:0] s_out;
  logic [1:0] s_acc_beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_last(acc_last),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_zero(out_zero), .acc_beats(acc_beats)
  );

  logic_gate_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_last(acc_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out(s_out),
    .out_zero(s_out_zero), .acc_beats(s_acc_beats)
  );

  // Offer one beat, let it transfer on the next edge, sample #1 after it.
  task automatic send_beat(input logic [7:0] va, input logic [7:0] vb, input op_t vop,
                           input logic ven, input logic vlast);
    a = va; b = vb; op = vop; acc_en = ven; acc_last = vlast; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL beat_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycle();
    checks++; if (out !== 8'h00)     begin errors++; $display("FAIL reset_out got %h want 00", out); end
    checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL reset_out_zero got %b want 1", out_zero); end
    checks++; if (acc_beats !== 8'd0) begin errors++; $display("FAIL reset_acc_beats got %0d want 0", acc_beats); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_direct_and();
    out_ready = 1'b1;
    send_beat(8'hF0, 8'h3C, OP_AND, 1'b0, 1'b0);
    checks++; if (out !== 8'h30)      begin errors++; $display("FAIL and_out got %h want 30", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_valid got %b want 1", out_valid); end
    checks++; if (out_zero !== 1'b0)  begin errors++; $display("FAIL and_zero got %b want 0", out_zero); end
    checks++; if (acc_beats !== 8'd1) begin errors++; $display("FAIL and_beats got %0d want 1", acc_beats); end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", out_valid); end
    checks++; if (out !== 8'h30)      begin errors++; $display("FAIL drain_out_held got %h want 30", out); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_beat(8'hA5, 8'h00, OP_NOT_A, 1'b0, 1'b0);
    // Second beat offered and held while the consumer stalls.
    a = 8'h12; b = 8'h34; op = OP_OR; acc_en = 1'b0; acc_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); end
      checks++; if (out !== 8'h5A)      begin errors++; $display("FAIL stall_out[%0d] got %h want 5a", i, out); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, out_valid); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out !== 8'h36)      begin errors++; $display("FAIL b2b_out got %h want 36", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", out_valid); end
    idle_cycle();
  endtask

  task automatic test_accum_xor();
    send_beat(8'h0F, 8'hF0, OP_XOR, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL xor_mid_valid got %b want 0", out_valid); end
    send_beat(8'hFF, 8'h00, OP_XOR, 1'b0, 1'b1);
    checks++; if (out !== 8'h00)      begin errors++; $display("FAIL xor_out got %h want 00", out); end
    checks++; if (out_zero !== 1'b1)  begin errors++; $display("FAIL xor_zero got %b want 1", out_zero); end
    checks++; if (acc_beats !== 8'd2) begin errors++; $display("FAIL xor_beats got %0d want 2", acc_beats); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL xor_valid got %b want 1", out_valid); end
  endtask

  task automatic test_accum_mixed();
    send_beat(8'h01, 8'h02, OP_OR, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mixed_b1_valid got %b want 0", out_valid); end
    send_beat(8'h04, 8'hFF, OP_OR, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mixed_b2_valid got %b want 0", out_valid); end
    send_beat(8'h06, 8'hFF, OP_AND, 1'b0, 1'b1);
    checks++; if (out !== 8'h06)      begin errors++; $display("FAIL mixed_out got %h want 06", out); end
    checks++; if (acc_beats !== 8'd3) begin errors++; $display("FAIL mixed_beats got %0d want 3", acc_beats); end
    checks++; if (out_zero !== 1'b0)  begin errors++; $display("FAIL mixed_zero got %b want 0", out_zero); end
  endtask

  task automatic test_saturation();
    logic [7:0] seq [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    for (int i = 0; i < 5; i++)
      send_beat(seq[i], 8'h00, OP_OR, (i == 0), (i == 4));
    checks++; if (s_out !== 8'h1F)       begin errors++; $display("FAIL sat_out got %h want 1f", s_out); end
    checks++; if (s_acc_beats !== 2'd3)  begin errors++; $display("FAIL sat_beats got %0d want 3", s_acc_beats); end
    checks++; if (acc_beats !== 8'd5)    begin errors++; $display("FAIL wide_beats got %0d want 5", acc_beats); end
    send_beat(8'hFF, 8'hFF, OP_NAND, 1'b1, 1'b1);
    checks++; if (s_out !== 8'h00)       begin errors++; $display("FAIL single_out got %h want 00", s_out); end
    checks++; if (s_acc_beats !== 2'd1)  begin errors++; $display("FAIL single_beats got %0d want 1", s_acc_beats); end
    checks++; if (s_out_valid !== 1'b1)  begin errors++; $display("FAIL single_valid got %b want 1", s_out_valid); end
    checks++; if (s_out_zero !== 1'b1)   begin errors++; $display("FAIL single_zero got %b want 1", s_out_zero); end
  endtask

  task automatic test_reset_in_accum();
    send_beat(8'h01, 8'h02, OP_OR, 1'b1, 1'b0);
    send_beat(8'h04, 8'h00, OP_OR, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_acc_valid got %b want 0", out_valid); end
    checks++; if (out !== 8'h00)      begin errors++; $display("FAIL rst_acc_out got %h want 00", out); end
    checks++; if (acc_beats !== 8'd0) begin errors++; $display("FAIL rst_acc_beats got %0d want 0", acc_beats); end
    send_beat(8'h55, 8'hFF, OP_XOR, 1'b0, 1'b0);
    checks++; if (out !== 8'hAA)      begin errors++; $display("FAIL post_rst_out got %h want aa", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b want 1", out_valid); end
    checks++; if (acc_beats !== 8'd1) begin errors++; $display("FAIL post_rst_beats got %0d want 1", acc_beats); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    acc_en = 1'b0; acc_last = 1'b0; out_ready = 1'b1;
    test_reset();
    test_direct_and();
    test_back_to_back();
    test_accum_xor();
    test_accum_mixed();
    test_saturation();
    test_reset_in_accum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Registered, parametrised logic unit that applies one of eight bitwise gate operations to WIDTH-bit operands under a valid/ready handshake. It is the multi-bit, sequential successor to the single-bit and/or/not gates. It adds an accumulate mode that folds a stream of operands into one result, so the microwave controller can combine multi-bit status and enable masks without external glue.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 8, width of the beat counter (≥1)

- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  unit can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (used only on first/only beat)
- op  input  3  opcode, see Operation
- acc_en  input  1  start accumulation (sampled only in IDLE)
- acc_last  input  1  final beat of accumulation
- out_valid  output  1  result held on out
- out_ready  input  1  consumer takes result
- out  output  WIDTH  registered result
- out_zero  output  1  registered, out == 0
- acc_beats  output  CNT_W  beats folded into out

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT_A (~x), 7 PASS_A (x). Each is applied bitwise as f(x, y).
- Accept: a beat transfers when in_valid && in_ready.
- in_ready = !out_valid || out_ready, combinational, in every state.
- FSM states: IDLE, ACCUM.
- IDLE, acc_en=0 (direct): out <= f(a, b), acc_beats <= 1, out_valid <= 1. State stays IDLE.
- IDLE, acc_en=1:
  - acc <= f(a, b), count <= 1.
  - If acc_last=1, it is a single-beat fold: the result goes straight to out with acc_beats=1, and the state stays IDLE.
  - Otherwise go to ACCUM.
- ACCUM, every accepted beat: acc <= f(a, acc). That is, x=a and y=acc. b is ignored. NOT_A and PASS_A discard acc. acc_en is ignored.
- ACCUM, beat count: count <= count+1, saturating at 2^CNT_W−1.
- ACCUM, beat with acc_last=1: out <= f(a, acc), acc_beats <= count+1 (saturating), out_valid <= 1, then go to IDLE.
- Non-last ACCUM beats do not change out or out_valid. A previous result may still be pending and drain concurrently.
- out_zero is computed from the value loaded into out and is registered with it.
- Output drain: when out_valid && out_ready and no new result loads, out_valid <= 0. out, out_zero and acc_beats keep their last values.
- Simultaneous drain and load: the new result replaces the old one and out_valid stays 1. No bubble.
- Reset values: out=0, out_zero=1, acc_beats=0, out_valid=0, internal acc=0, count=0, state IDLE. in_ready=1 the cycle after reset.
- Reset during ACCUM: the partial accumulation is discarded and no result is emitted.

## Timing
- Latency: 1 cycle from an accepted direct or last beat to out_valid=1 with its result.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0. No beat is accepted and all outputs are held stable.
- in_valid/a/b/op/acc_en/acc_last need to be stable only in the accepting cycle.
- No combinational path from in_valid to out_valid. The only combinational paths are out_valid/out_ready → in_ready.

## Structure
- Package logic_gate_pkg:
  - op_t enum with the eight opcodes
  - state_t enum {IDLE, ACCUM}
  - opcode width constant 3
- Sub-module gate_alu: combinational, parametrised by WIDTH, inputs x, y, op, output f(x, y).
  - One instance.
  - y is muxed: b in IDLE, acc in ACCUM.
- Top level holds the FSM, acc/count registers, output register and handshake.

## Test plan
- WIDTH=8, direct AND, a=0xF0 b=0x3C, out_ready=1 → next cycle out=0x30, out_valid=1, out_zero=0, acc_beats=1.
- Direct NOT_A a=0xA5, with out_ready=0 for 3 cycles and a second beat offered → out=0x5A held, in_ready=0 for 3 cycles. Second beat is accepted in the cycle out_ready rises, and its result appears with no bubble.
- Accumulate XOR:
  - Beat 1 (acc_en=1, a=0x0F, b=0xF0, XOR).
  - Beat 2 (a=0xFF, XOR, acc_last=1).
  - → out=0x00, out_zero=1, acc_beats=2. out_valid only after beat 2.
- Accumulate with mixed ops:
  - Beat 1 OR (a=0x01, b=0x02).
  - Beat 2 OR a=0x04.
  - Beat 3 AND a=0x06, last.
  - → out=0x06, acc_beats=3.
- CNT_W=2, 5-beat OR accumulation → acc_beats=3 (saturated). Then a single-beat acc_en=1, acc_last=1, NAND a=0xFF b=0xFF → out=0x00, acc_beats=1.
- rst asserted after beat 2 of a non-last accumulation → out_valid=0, out=0, state IDLE. A following direct XOR a=0x55 b=0xFF gives out=0xAA.
